// File: rtl/fetch_pkg.sv
// Shared types and defaults for the fetch unit: state encoding, bus widths and the
// per-thread read-buffer entry.
package fetch_pkg;

    localparam int unsigned AW_DEFAULT = 32;
    localparam int unsigned DW_DEFAULT = 32;
    localparam int unsigned TW_DEFAULT = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        ACK  = 2'd2
    } state_e;

    typedef struct packed {
        logic                  valid;
        logic [AW_DEFAULT-1:0] addr;
        logic [DW_DEFAULT-1:0] data;
    } rdbuf_entry_t;

endpackage

// File: rtl/fetch_if.sv
// W_ bus bundle between the fetch unit (master) and external memory (slave).
interface fetch_if
    import fetch_pkg::*;
#(
    parameter int unsigned AW = AW_DEFAULT,
    parameter int unsigned DW = DW_DEFAULT
);
    logic          W_ACK;
    logic [DW-1:0] W_DATA_I;
    logic [DW-1:0] W_DATA_O;
    logic [AW-1:0] W_ADDR;
    logic          W_WRITE;
    logic          W_STB;

    modport master (
        input  W_ACK, W_DATA_I,
        output W_DATA_O, W_ADDR, W_WRITE, W_STB
    );

    modport slave (
        output W_ACK, W_DATA_I,
        input  W_DATA_O, W_ADDR, W_WRITE, W_STB
    );
endinterface

// File: rtl/fetch_rdbuf.sv
// Per-thread read buffer: one {valid, addr, data} entry per thread, filled on read
// misses and kept coherent by write-through updates to every matching entry.
module fetch_rdbuf
    import fetch_pkg::*;
#(
    parameter int unsigned TW = TW_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [TW-1:0]         lk_thread,
    input  logic [AW_DEFAULT-1:0] lk_addr,
    output logic                  hit_c,
    output logic [DW_DEFAULT-1:0] hit_data_c,
    input  logic                  fill_en,
    input  logic [TW-1:0]         fill_thread,
    input  logic [AW_DEFAULT-1:0] fill_addr,
    input  logic [DW_DEFAULT-1:0] fill_data,
    input  logic                  upd_en,
    input  logic [AW_DEFAULT-1:0] upd_addr,
    input  logic [DW_DEFAULT-1:0] upd_data
);
    localparam int unsigned NE = 2 ** TW;

    rdbuf_entry_t entry_q [NE];
    rdbuf_entry_t entry_d [NE];

    assign hit_c      = entry_q[lk_thread].valid && (entry_q[lk_thread].addr == lk_addr);
    assign hit_data_c = entry_q[lk_thread].data;

    // A write may alias several threads' entries, so all of them are refreshed.
    always_comb begin
        for (int i = 0; i < NE; i++) begin
            entry_d[i] = entry_q[i];
            if (upd_en && entry_q[i].valid && (entry_q[i].addr == upd_addr)) begin
                entry_d[i].data = upd_data;
            end
        end
        if (fill_en) begin
            entry_d[fill_thread] = '{valid: 1'b1, addr: fill_addr, data: fill_data};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NE; i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            entry_q <= entry_d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Core-to-W_ bus bridge: one request at a time, single bus transaction, one-cycle ack.
// Optional per-thread read buffer enabled by defining FETCH_CACHE_EN.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned AW = AW_DEFAULT,
    parameter int unsigned DW = DW_DEFAULT,
    parameter int unsigned TW = TW_DEFAULT
) (
    input  logic          clk,
    input  logic          W_RST,
    input  logic          enable,
    input  logic          write_enable,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] data_i,
    input  logic [TW-1:0] thread,
    output logic [DW-1:0] data_o,
    output logic          ack,
    fetch_if.master       bus
);
    state_e        state_q, state_d;
    logic          ack_q, ack_d;
    logic [DW-1:0] data_o_q, data_o_d;
    logic          stb_q, stb_d;
    logic          write_q, write_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          rd_hit_c;
    logic [DW-1:0] rd_hit_data_c;
    logic          bus_done_c;

    assign bus_done_c = (state_q == BUS) && bus.W_ACK;

`ifdef FETCH_CACHE_EN
    logic [TW-1:0] thread_q, thread_d;

    fetch_rdbuf #(.TW(TW)) u_rdbuf (
        .clk        (clk),
        .rst_n      (W_RST),
        .lk_thread  (thread),
        .lk_addr    (addr),
        .hit_c      (rd_hit_c),
        .hit_data_c (rd_hit_data_c),
        .fill_en    (bus_done_c && !write_q),
        .fill_thread(thread_q),
        .fill_addr  (addr_q),
        .fill_data  (bus.W_DATA_I),
        .upd_en     (bus_done_c && write_q),
        .upd_addr   (addr_q),
        .upd_data   (wdata_q)
    );
`else
    logic unused_thread;
    assign unused_thread = ^thread;
    assign rd_hit_c      = 1'b0;
    assign rd_hit_data_c = '0;
`endif

    always_comb begin
        state_d  = state_q;
        ack_d    = 1'b0;
        data_o_d = data_o_q;
        stb_d    = stb_q;
        write_d  = write_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
`ifdef FETCH_CACHE_EN
        thread_d = thread_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (enable) begin
                    if (rd_hit_c && !write_enable) begin
                        data_o_d = rd_hit_data_c;
                        ack_d    = 1'b1;
                        state_d  = ACK;
                    end else begin
                        addr_d   = addr;
                        wdata_d  = data_i;
                        write_d  = write_enable;
                        stb_d    = 1'b1;
`ifdef FETCH_CACHE_EN
                        thread_d = thread;
`endif
                        state_d  = BUS;
                    end
                end
            end
            BUS: begin
                if (bus.W_ACK) begin
                    stb_d   = 1'b0;
                    write_d = 1'b0;
                    if (!write_q) begin
                        data_o_d = bus.W_DATA_I;
                    end
                    ack_d   = 1'b1;
                    state_d = ACK;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Reset drops W_STB immediately, aborting any bus transaction in flight.
    always_ff @(posedge clk) begin
        if (!W_RST) begin
            state_q  <= IDLE;
            ack_q    <= 1'b0;
            data_o_q <= '0;
            stb_q    <= 1'b0;
            write_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
`ifdef FETCH_CACHE_EN
            thread_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            ack_q    <= ack_d;
            data_o_q <= data_o_d;
            stb_q    <= stb_d;
            write_q  <= write_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
`ifdef FETCH_CACHE_EN
            thread_q <= thread_d;
`endif
        end
    end

    assign ack          = ack_q;
    assign data_o       = data_o_q;
    assign bus.W_STB    = stb_q;
    assign bus.W_WRITE  = write_q;
    assign bus.W_ADDR   = addr_q;
    assign bus.W_DATA_O = wdata_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic
// against a memory/read-buffer reference model.
module tb_fetch_unit;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        W_RST;
    logic        enable;
    logic        write_enable;
    logic [31:0] addr;
    logic [31:0] data_i;
    logic [1:0]  thread;
    logic [31:0] data_o;
    logic        ack;

    fetch_if bus ();

    fetch_unit dut (
        .clk         (clk),
        .W_RST       (W_RST),
        .enable      (enable),
        .write_enable(write_enable),
        .addr        (addr),
        .data_i      (data_i),
        .thread      (thread),
        .data_o      (data_o),
        .ack         (ack),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: flat memory, the visible data_o, and one buffered line per thread.
    logic [31:0] mem [logic [31:0]];
    logic [31:0] m_data_o;
    bit          c_valid [4];
    logic [31:0] c_addr  [4];
    logic [31:0] c_data  [4];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", tag, got, exp);
    endtask

    task automatic model_reset();
        m_data_o = '0;
        for (int i = 0; i < 4; i++) c_valid[i] = 1'b0;
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (!mem.exists(a)) mem[a] = $urandom;
        return mem[a];
    endfunction

    // One complete request; the bus stub answers after wait_cyc idle bus cycles.
    task automatic run_txn(input logic we, input logic [31:0] a, input logic [31:0] d,
                           input logic [1:0] th, input int wait_cyc);
        logic        hit;
        logic [31:0] rv;
        hit = 1'b0;
`ifdef FETCH_CACHE_EN
        hit = !we && c_valid[th] && (c_addr[th] == a);
`endif
        rv = hit ? c_data[th] : mem_rd(a);

        @(negedge clk);
        enable = 1'b1; write_enable = we; addr = a; data_i = d; thread = th;
        bus.W_ACK = 1'b0; bus.W_DATA_I = $urandom;
        @(posedge clk); #1;
        enable = 1'b0; write_enable = 1'($urandom); addr = $urandom; data_i = $urandom;
        thread = 2'($urandom);

        if (hit) begin
            m_data_o = rv;
            check("hit_stb", bus.W_STB, 0);
            check("hit_ack", ack, 1);
            check("hit_data", data_o, m_data_o);
        end else begin
            check("req_stb", bus.W_STB, 1);
            check("req_write", bus.W_WRITE, we);
            check("req_addr", bus.W_ADDR, a);
            if (we) check("req_wdata", bus.W_DATA_O, d);
            for (int k = 0; k <= wait_cyc; k++) begin
                @(negedge clk);
                bus.W_ACK    = (k == wait_cyc);
                bus.W_DATA_I = (k == wait_cyc && !we) ? rv : $urandom;
                @(posedge clk); #1;
                if (k < wait_cyc) begin
                    check("wait_stb", bus.W_STB, 1);
                    check("wait_ack", ack, 0);
                    check("wait_write", bus.W_WRITE, we);
                    check("wait_addr", bus.W_ADDR, a);
                end
            end
            if (we) begin
                mem[a] = d;
                for (int i = 0; i < 4; i++)
                    if (c_valid[i] && c_addr[i] == a) c_data[i] = d;
            end else begin
                m_data_o   = rv;
                c_valid[th] = 1'b1;
                c_addr[th]  = a;
                c_data[th]  = rv;
            end
            check("done_ack", ack, 1);
            check("done_stb", bus.W_STB, 0);
            check("done_write", bus.W_WRITE, 0);
            check("done_data", data_o, m_data_o);
        end

        @(negedge clk);
        bus.W_ACK = 1'($urandom);
        bus.W_DATA_I = $urandom;
        @(posedge clk); #1;
        check("ack_drop", ack, 0);
        check("ack_stb", bus.W_STB, 0);
        check("ack_data_hold", data_o, m_data_o);
        bus.W_ACK = 1'b0;
    endtask

    initial begin
        int          n_ack;
        logic [31:0] rv;

        W_RST = 1'b0; enable = 1'b0; write_enable = 1'b0; addr = '0; data_i = '0;
        thread = '0; bus.W_ACK = 1'b0; bus.W_DATA_I = '0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_ack", ack, 0);
        check("rst_data_o", data_o, 0);
        check("rst_stb", bus.W_STB, 0);
        check("rst_write", bus.W_WRITE, 0);
        check("rst_addr", bus.W_ADDR, 0);
        check("rst_wdata", bus.W_DATA_O, 0);
        @(negedge clk);
        W_RST = 1'b1;

        // Directed read and write
        mem[32'h10] = 32'hDEAD_BEEF;
        run_txn(1'b0, 32'h10, 32'h0, 2'd0, 0);
        check("read_deadbeef", data_o, 32'hDEAD_BEEF);
        run_txn(1'b1, 32'h20, 32'h1234_5678, 2'd0, 3);
        check("write_keeps_data_o", data_o, 32'hDEAD_BEEF);

        // Reset during BUS aborts without ack
        @(negedge clk);
        enable = 1'b1; write_enable = 1'b0; addr = 32'h30; thread = 2'd2; bus.W_ACK = 1'b0;
        @(posedge clk); #1;
        enable = 1'b0;
        check("abort_stb_before", bus.W_STB, 1);
        @(negedge clk);
        W_RST = 1'b0;
        @(posedge clk); #1;
        model_reset();
        check("abort_stb", bus.W_STB, 0);
        check("abort_ack", ack, 0);
        check("abort_data_o", data_o, 0);
        check("abort_addr", bus.W_ADDR, 0);
        @(negedge clk);
        W_RST = 1'b1;
        @(posedge clk); #1;
        check("abort_no_late_ack", ack, 0);
        run_txn(1'b0, 32'h30, 32'h0, 2'd2, 1);

        // enable held through ack starts exactly one more transaction
        rv = mem_rd(32'h50);
        @(negedge clk);
        enable = 1'b1; write_enable = 1'b0; addr = 32'h50; thread = 2'd3;
        bus.W_ACK = 1'b1; bus.W_DATA_I = rv;
        n_ack = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (ack) n_ack++;
            if (c == 3) enable = 1'b0;
        end
        bus.W_ACK = 1'b0;
        m_data_o = rv; c_valid[3] = 1'b1; c_addr[3] = 32'h50; c_data[3] = rv;
        check("held_enable_acks", 64'(n_ack), 2);
        check("held_enable_data", data_o, m_data_o);

        // Read-buffer scenario: repeat read, then write-through update
        run_txn(1'b0, 32'h40, 32'h0, 2'd1, 1);
        run_txn(1'b0, 32'h40, 32'h0, 2'd1, 0);
        run_txn(1'b1, 32'h40, 32'h5, 2'd0, 0);
        run_txn(1'b0, 32'h40, 32'h0, 2'd1, 2);
        check("write_then_read", data_o, 32'h5);

        // Randomized traffic with idle cycles carrying stray W_ACK
        for (int n = 0; n < 60; n++) begin
            run_txn(($urandom_range(0, 2) == 0), 32'h40 + 32'(4 * $urandom_range(0, 7)),
                    $urandom, 2'($urandom), int'($urandom_range(0, 3)));
            if ($urandom_range(0, 1) == 1) begin
                @(negedge clk);
                bus.W_ACK = 1'b1; bus.W_DATA_I = $urandom;
                @(posedge clk); #1;
                check("idle_stray_ack", ack, 0);
                check("idle_stb", bus.W_STB, 0);
                check("idle_data_hold", data_o, m_data_o);
                bus.W_ACK = 1'b0;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
